// File: rtl/s_arbiter.sv
// ----------------------------------------------------------------------------
// s_arbiter : two-master round-robin slave-side arbiter, one txn outstanding.
// Optional: define ARB_TIMEOUT_EN for SEND/WAIT_RD timeout with m_err.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module s_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int TO_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_cmd,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_cmd,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [1:0]    m_ack,
  output logic [DW-1:0] m_rdata,
  output logic          m_err,
  output logic          s_req,
  output logic          s_cmd,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic          s_ack,
  input  logic          s_resp,
  input  logic [DW-1:0] s_rdata,
  output logic          grant
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SEND    = 2'd1;
  localparam logic [1:0] WAIT_RD = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  if (TO_CYCLES < 2) begin : g_to_cycles_check
    $error("s_arbiter: TO_CYCLES must be at least 2");
  end

  logic [1:0]    state_q, state_d;
  logic          ptr_q, ptr_d;      // 1 = master 1 preferred on contention
  logic          grant_q, grant_d;
  logic          cmd_q, cmd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          win;

`ifdef ARB_TIMEOUT_EN
  localparam int            CW      = $clog2(TO_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          timeout;

  assign timeout = (cnt_q == TO_LAST);
`endif

  always_comb begin
    if (m0_req && m1_req) begin
      win = ptr_q;
    end else begin
      win = m1_req;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = '0;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant_d = win;
          ptr_d   = ~win;
          cmd_d   = win ? m1_cmd   : m0_cmd;
          addr_d  = win ? m1_addr  : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
          state_d = SEND;
        end
      end
      SEND: begin
        if (s_ack) begin
          state_d = cmd_q ? DONE : WAIT_RD;
`ifdef ARB_TIMEOUT_EN
        end else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
`endif
        end
      end
      WAIT_RD: begin
        if (s_resp) begin
          rdata_d = s_rdata;
          state_d = DONE;
`ifdef ARB_TIMEOUT_EN
        end else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      grant_q <= 1'b0;
      cmd_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign m_err = err_q;
`else
  assign m_err = 1'b0;
`endif

  // Slave and master handshakes are decoded straight from the registered state.
  assign s_req   = (state_q == SEND);
  assign m_ack   = (state_q == DONE) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign s_cmd   = cmd_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;
  assign m_rdata = rdata_q;
  assign grant   = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_s_arbiter.sv
// ----------------------------------------------------------------------------
// tb_s_arbiter : directed self-checking bench for s_arbiter (ARB_TIMEOUT_EN aware).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_s_arbiter;

  localparam int AW        = 8;
  localparam int DW        = 8;
  localparam int TO_CYCLES = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_cmd, m1_req, m1_cmd;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [1:0]    m_ack;
  logic [DW-1:0] m_rdata;
  logic          m_err;
  logic          s_req, s_cmd;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_ack, s_resp;
  logic [DW-1:0] s_rdata;
  logic          grant;

  int vectors    = 0;
  int miscompares = 0;

  s_arbiter #(.AW(AW), .DW(DW), .TO_CYCLES(TO_CYCLES)) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_req   (m0_req),
    .m0_cmd   (m0_cmd),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m1_req   (m1_req),
    .m1_cmd   (m1_cmd),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m_ack    (m_ack),
    .m_rdata  (m_rdata),
    .m_err    (m_err),
    .s_req    (s_req),
    .s_cmd    (s_cmd),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_ack    (s_ack),
    .s_resp   (s_resp),
    .s_rdata  (s_rdata),
    .grant    (grant)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs every master/slave-facing output for an all-outputs comparison.
  function automatic logic [31:0] outs();
    return {3'b0, grant, m_err, m_ack, s_req, s_cmd, s_addr, s_wdata, m_rdata};
  endfunction

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_cmd = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_cmd = 0; m1_addr = '0; m1_wdata = '0;
    s_ack = 0; s_resp = 0; s_rdata = '0;
    step(); step();
    check("reset_outputs", outs(), 32'h0);
    rst = 1'b0;
    step();
    check("idle_no_req", outs(), 32'h0);

    // m0 WRITE 0x12 <- 0xA5; slave acks in the second SEND cycle
    m0_req = 1; m0_cmd = 1; m0_addr = 8'h12; m0_wdata = 8'hA5;
    step();
    check("wr_s_req", s_req, 1);
    check("wr_s_addr", s_addr, 8'h12);
    check("wr_s_wdata", s_wdata, 8'hA5);
    check("wr_s_cmd", s_cmd, 1);
    check("wr_grant", grant, 0);
    check("wr_no_ack_send", m_ack, 2'b00);
    step();
    check("wr_send_hold", s_req, 1);
    s_ack = 1;
    step();
    s_ack = 0; m0_req = 0;
    check("wr_ack", m_ack, 2'b01);
    check("wr_done_s_req", s_req, 0);
    step();
    check("wr_ack_one_cycle", m_ack, 2'b00);

    // m1 READ 0x34; response 0x5C three cycles after the ack
    m1_req = 1; m1_cmd = 0; m1_addr = 8'h34;
    step();
    check("rd_grant", grant, 1);
    check("rd_s_addr", s_addr, 8'h34);
    check("rd_s_cmd", s_cmd, 0);
    s_ack = 1;
    step();
    s_ack = 0;
    check("rd_wait_s_req0", s_req, 0);
    check("rd_wait_no_ack0", m_ack, 2'b00);
    step();
    check("rd_wait_s_req1", s_req, 0);
    step();
    check("rd_wait_s_req2", s_req, 0);
    check("rd_wait_no_ack2", m_ack, 2'b00);
    s_resp = 1; s_rdata = 8'h5C;
    step();
    s_resp = 0; s_rdata = 8'h00; m1_req = 0;
    check("rd_ack", m_ack, 2'b10);
    check("rd_rdata", m_rdata, 8'h5C);
    step();
    check("rd_ack_one_cycle", m_ack, 2'b00);
    check("rd_rdata_hold", m_rdata, 8'h5C);

    // continuous contention: grants alternate 0,1,0,1
    m0_req = 1; m0_cmd = 1; m0_addr = 8'h01; m0_wdata = 8'h10;
    m1_req = 1; m1_cmd = 1; m1_addr = 8'h02; m1_wdata = 8'h20;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_grant", grant, i % 2);
      check("rr_addr", s_addr, (i % 2 == 0) ? 8'h01 : 8'h02);
      s_ack = 1;
      step();
      s_ack = 0;
      check("rr_ack", m_ack, (i % 2 == 0) ? 2'b01 : 2'b10);
      step();
      check("rr_ack_once", m_ack, 2'b00);
    end
    m0_req = 0; m1_req = 0;
    step();

    // SEND ignores master-side changes and s_resp
    m0_req = 1; m0_cmd = 1; m0_addr = 8'h56; m0_wdata = 8'h11;
    step();
    check("ign_send", s_req, 1);
    m0_addr = 8'hFF; s_resp = 1;
    step();
    s_resp = 0;
    check("ign_addr", s_addr, 8'h56);
    check("ign_still_send", s_req, 1);
    check("ign_no_ack", m_ack, 2'b00);
    step();
    check("ign_still_send2", s_req, 1);
    s_ack = 1;
    step();
    s_ack = 0; m0_req = 0;
    check("ign_ack", m_ack, 2'b01);
    step();

    // reset in WAIT_RD aborts silently and restores master-0 priority
    m1_req = 1; m1_cmd = 0; m1_addr = 8'h77;
    step();
    check("rst_pre_grant", grant, 1);
    s_ack = 1;
    step();
    s_ack = 0;
    check("rst_in_wait", s_req, 0);
    rst = 1; m0_req = 1; m0_cmd = 1; m0_addr = 8'h9A; m0_wdata = 8'h3C;
    step();
    rst = 0;
    check("rst_mid_outputs", outs(), 32'h0);
    step();
    check("rst_post_grant", grant, 0);
    check("rst_post_s_req", s_req, 1);
    check("rst_post_addr", s_addr, 8'h9A);
    check("rst_post_no_ack", m_ack, 2'b00);
    s_ack = 1;
    step();
    s_ack = 0; m0_req = 0; m1_req = 0;
    check("rst_post_ack", m_ack, 2'b01);
    step();

    // slave never acknowledges
    m0_req = 1; m0_cmd = 1; m0_addr = 8'h44;
    step();
    check("to_send", s_req, 1);
`ifdef ARB_TIMEOUT_EN
    begin
      int waited = 0;
      while (m_ack == 2'b00 && waited < 4 * TO_CYCLES) begin
        step();
        waited++;
        if (waited < TO_CYCLES) check("to_err_low", m_err, 0);
      end
      check("to_cycles", waited, TO_CYCLES);
      check("to_ack", m_ack, 2'b01);
      check("to_err", m_err, 1);
      check("to_s_req", s_req, 0);
      check("to_rdata_keep", m_rdata, 8'h00);
      m0_req = 0;
      step();
      check("to_err_clear", m_err, 0);
    end
`else
    for (int i = 0; i < TO_CYCLES + 4; i++) begin
      step();
      check("nto_s_req", s_req, 1);
      check("nto_err", m_err, 0);
      check("nto_ack", m_ack, 2'b00);
    end
    m0_req = 0;
    rst = 1;
    step();
    rst = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
